// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detector pipeline: scan FSM states,
// default image geometry (also used by the downstream line buffers) and a
// small sizing helper for the blanking counter.
package edge_pkg;

  // Default frame geometry shared across the pipeline
  localparam int DEF_IMG_W  = 64;
  localparam int DEF_IMG_H  = 64;
  localparam int DEF_HBLANK = 4;
  localparam int DEF_VBLANK = 8;
  localparam int DEF_ADDR_W = 12;

  // Raster scan controller states
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_VBLANK
  } scan_state_t;

  // Width of a counter that must reach max(hb, vb)-1; never narrower than
  // one bit so the counter still exists when both blankings are zero.
  function automatic int blank_cnt_width(input int hb, input int vb);
    int m;
    m = (hb > vb) ? hb : vb;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pixel_scan_gen_rise_detect.sv
// Single-bit rising-edge detector for signals already in the local clock
// domain (e.g. a divided clock produced by a divider on the same clock).
// No synchroniser: the input is assumed to be a register of this domain.
module rise_detect (
  input  logic origin_clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_d_q;

  // Remember last cycle's level; cleared so a high input at reset
  // release is seen as a rising edge.
  always_ff @(posedge origin_clk or negedge reset) begin
    if (!reset) begin
      sig_d_q <= 1'b0;
    end else begin
      sig_d_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_d_q;

endmodule

// File: rtl/pixel_scan_gen.sv
// Raster-scan pixel timing generator. Turns rising edges of the divided
// clock into pixel ticks and walks an IMG_W x IMG_H frame with horizontal
// and vertical blanking, emitting frame-buffer read strobes, the read
// address, pixel coordinates and line/frame markers.
module pixel_scan_gen
  import edge_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int HBLANK = DEF_HBLANK,
  parameter int VBLANK = DEF_VBLANK,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                       origin_clk,
  input  logic                       reset,
  input  logic                       div_clk_i,
  input  logic                       start_i,
  input  logic                       continuous_i,
  output logic                       rd_en_o,
  output logic [ADDR_W-1:0]          rd_addr_o,
  output logic [$clog2(IMG_W)-1:0]   pix_x_o,
  output logic [$clog2(IMG_H)-1:0]   pix_y_o,
  output logic                       line_start_o,
  output logic                       frame_start_o,
  output logic                       frame_end_o,
  output logic                       busy_o
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int BW = blank_cnt_width(HBLANK, VBLANK);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [BW-1:0] H_LAST = BW'((HBLANK > 0) ? HBLANK - 1 : 0);
  localparam logic [BW-1:0] V_LAST = BW'((VBLANK > 0) ? VBLANK - 1 : 0);

  // Scan position of the next pixel to be emitted
  scan_state_t       state_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BW-1:0]     blank_q;

  // Registered copies of everything presented on the outputs
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [XW-1:0]     pix_x_q;
  logic [YW-1:0]     pix_y_q;
  logic              line_start_q;
  logic              frame_start_q;
  logic              frame_end_q;
  logic              busy_q;

  logic tick;
  logic last_x;
  logic last_y;
  logic emit;

  rise_detect u_tick (
    .origin_clk (origin_clk),
    .reset      (reset),
    .sig_i      (div_clk_i),
    .rise_o     (tick)
  );

  assign last_x = (x_q == X_LAST);
  assign last_y = (y_q == Y_LAST);

  // A pixel goes out on every tick in ACTIVE, and on the tick that
  // leaves IDLE so (0,0) is read without waiting a further tick.
  assign emit = tick && ((state_q == S_ACTIVE) ||
                         ((state_q == S_IDLE) && start_i));

  // Scan FSM: position counters, blanking counter and registered outputs.
  // Pulses default low every cycle so they last exactly one cycle; the
  // address/coordinate outputs hold until the next emitted pixel.
  always_ff @(posedge origin_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      blank_q       <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rd_en_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;

      if (emit) begin
        rd_en_q       <= 1'b1;
        rd_addr_q     <= addr_q;
        pix_x_q       <= x_q;
        pix_y_q       <= y_q;
        line_start_q  <= (x_q == '0);
        frame_start_q <= (x_q == '0) && (y_q == '0);
        frame_end_q   <= last_x && last_y;
        busy_q        <= 1'b1;

        if (!last_x) begin
          x_q     <= x_q + 1'b1;
          addr_q  <= addr_q + 1'b1;
          state_q <= S_ACTIVE;
        end else if (!last_y) begin
          x_q     <= '0;
          y_q     <= y_q + 1'b1;
          addr_q  <= addr_q + 1'b1;
          state_q <= (HBLANK > 0) ? S_HBLANK : S_ACTIVE;
        end else begin
          // Last pixel of the frame: address wraps here rather than by
          // recomputation, so the counters are ready for the next frame.
          x_q    <= '0;
          y_q    <= '0;
          addr_q <= '0;
          if (VBLANK > 0) begin
            state_q <= S_VBLANK;
          end else if (continuous_i) begin
            state_q <= S_ACTIVE;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
      end else if (tick) begin
        case (state_q)
          S_HBLANK: begin
            if (blank_q == H_LAST) begin
              blank_q <= '0;
              state_q <= S_ACTIVE;
            end else begin
              blank_q <= blank_q + 1'b1;
            end
          end
          S_VBLANK: begin
            // continuous is only consulted here, so dropping it mid-frame
            // still lets the current frame finish.
            if (blank_q == V_LAST) begin
              blank_q <= '0;
              if (continuous_i) begin
                state_q <= S_ACTIVE;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              blank_q <= blank_q + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign rd_en_o       = rd_en_q;
  assign rd_addr_o     = rd_addr_q;
  assign pix_x_o       = pix_x_q;
  assign pix_y_o       = pix_y_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
  assign frame_end_o   = frame_end_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Directed bench for pixel_scan_gen on a 4x2 frame. Instance A uses one
// blank tick per line and two per frame; instance B has no blanking.
module tb_pixel_scan_gen;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic divClk = 1'b0;
  logic startA = 1'b0, contA = 1'b0, startB = 1'b0, contB = 1'b0;

  logic          rdEnA, lsA, fsA, feA, busyA;
  logic [AW-1:0] rdAddrA;
  logic [1:0]    pixXA;
  logic [0:0]    pixYA;
  logic          rdEnB, lsB, fsB, feB, busyB;
  logic [AW-1:0] rdAddrB;
  logic [1:0]    pixXB;
  logic [0:0]    pixYB;

  logic          useB = 1'b0;
  logic          obsRdEn, obsLs, obsFs, obsFe;
  logic [AW-1:0] obsAddr;
  logic [1:0]    obsX;
  logic [0:0]    obsY;

  int  total = 0;
  int  bad = 0;
  int  divVal = 0;
  int  divCnt = 0;
  bit  divEn = 1'b1;
  int  cyc = 0;
  int  lastPix = 0;

  always #5 clk = ~clk;

  assign obsRdEn = useB ? rdEnB   : rdEnA;
  assign obsLs   = useB ? lsB     : lsA;
  assign obsFs   = useB ? fsB     : fsA;
  assign obsFe   = useB ? feB     : feA;
  assign obsAddr = useB ? rdAddrB : rdAddrA;
  assign obsX    = useB ? pixXB   : pixXA;
  assign obsY    = useB ? pixYB   : pixYA;

  pixel_scan_gen #(.IMG_W(W), .IMG_H(H), .HBLANK(1), .VBLANK(2), .ADDR_W(AW)) dutA (
    .origin_clk(clk), .reset(resetN), .div_clk_i(divClk),
    .start_i(startA), .continuous_i(contA),
    .rd_en_o(rdEnA), .rd_addr_o(rdAddrA), .pix_x_o(pixXA), .pix_y_o(pixYA),
    .line_start_o(lsA), .frame_start_o(fsA), .frame_end_o(feA), .busy_o(busyA)
  );

  pixel_scan_gen #(.IMG_W(W), .IMG_H(H), .HBLANK(0), .VBLANK(0), .ADDR_W(AW)) dutB (
    .origin_clk(clk), .reset(resetN), .div_clk_i(divClk),
    .start_i(startB), .continuous_i(contB),
    .rd_en_o(rdEnB), .rd_addr_o(rdAddrB), .pix_x_o(pixXB), .pix_y_o(pixYB),
    .line_start_o(lsB), .frame_start_o(fsB), .frame_end_o(feB), .busy_o(busyB)
  );

  // Advance to the next falling edge and step the divided-clock model:
  // divider value D toggles div_clk every D+1 cycles.
  task automatic applyStimulus();
    @(negedge clk);
    cyc++;
    if (divEn) begin
      divCnt++;
      if (divCnt > divVal) begin
        divClk = ~divClk;
        divCnt = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait for the next read strobe, then check address, coordinates,
  // markers and optionally the spacing from the previous strobe and that
  // all pulses are gone one cycle later.
  task automatic checkPixel(input int expAddr, input int expGap, input bit doWidth);
    int n;
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (obsRdEn !== 1'b1 && n < 200);
    if (obsRdEn !== 1'b1) checkOutput("pixel_timeout", obsRdEn, 1);
    if (expGap > 0) checkOutput("rd_gap", cyc - lastPix, expGap);
    lastPix = cyc;
    checkOutput("rd_addr", obsAddr, expAddr);
    checkOutput("pix_x", obsX, expAddr % W);
    checkOutput("pix_y", obsY, expAddr / W);
    checkOutput("line_start", obsLs, (expAddr % W) == 0);
    checkOutput("frame_start", obsFs, expAddr == 0);
    checkOutput("frame_end", obsFe, expAddr == W * H - 1);
    if (doWidth) begin
      applyStimulus();
      checkOutput("pulse_width", {obsRdEn, obsLs, obsFs, obsFe}, 0);
    end
  endtask

  initial begin
    int cnt;
    int n;

    // Reset state
    repeat (3) applyStimulus();
    checkOutput("reset_rd_en_a", rdEnA, 0);
    checkOutput("reset_busy_a", busyA, 0);
    checkOutput("reset_addr_a", rdAddrA, 0);
    checkOutput("reset_markers_a", {lsA, fsA, feA, pixXA, pixYA}, 0);
    checkOutput("reset_busy_b", busyB, 0);
    checkOutput("reset_rd_en_b", rdEnB, 0);
    resetN = 1'b1;

    // Single frame, divider 0, non-continuous
    $display("[TB] single frame");
    startA = 1'b1;
    contA = 1'b0;
    checkPixel(0, 0, 1);
    startA = 1'b0;
    checkOutput("busy_rise", busyA, 1);
    for (int a = 1; a < 8; a++) checkPixel(a, (a == 4) ? 4 : 2, 1);
    repeat (2) applyStimulus();
    checkOutput("busy_in_vblank", busyA, 1);
    applyStimulus();
    checkOutput("busy_fall", busyA, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      if (rdEnA) cnt++;
    end
    checkOutput("idle_quiet", cnt, 0);

    // Continuous for two frames, dropped during the second
    $display("[TB] continuous frames");
    startA = 1'b1;
    contA = 1'b1;
    checkPixel(0, 0, 1);
    startA = 1'b0;
    for (int a = 1; a < 8; a++) checkPixel(a, (a == 4) ? 4 : 2, 1);
    checkPixel(0, 6, 1);
    checkPixel(1, 2, 1);
    contA = 1'b0;
    for (int a = 2; a < 8; a++) checkPixel(a, (a == 4) ? 4 : 2, 1);
    repeat (2) applyStimulus();
    checkOutput("cont_busy_vblank", busyA, 1);
    applyStimulus();
    checkOutput("cont_busy_fall", busyA, 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus();
      if (rdEnA) cnt++;
    end
    checkOutput("cont_idle_quiet", cnt, 0);

    // Divider 3: one tick per 8 cycles, then div_clk stuck low
    $display("[TB] divider 3 and stall");
    divVal = 3;
    divCnt = 0;
    startA = 1'b1;
    checkPixel(0, 0, 1);
    startA = 1'b0;
    checkPixel(1, 8, 1);
    checkPixel(2, 8, 1);
    divEn = 1'b0;
    divClk = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (rdEnA) cnt++;
    end
    checkOutput("stall_no_rd", cnt, 0);
    checkOutput("stall_addr_hold", rdAddrA, 2);
    checkOutput("stall_x_hold", pixXA, 2);
    checkOutput("stall_busy_hold", busyA, 1);
    checkOutput("stall_pulses_low", {lsA, fsA, feA}, 0);
    divEn = 1'b1;
    divCnt = 0;
    checkPixel(3, 0, 1);
    checkPixel(4, 16, 1);
    for (int a = 5; a < 8; a++) checkPixel(a, 8, 1);
    n = 0;
    while (busyA === 1'b1 && n < 100) begin
      applyStimulus();
      n++;
    end
    checkOutput("d3_busy_fall_delay", n, 15);

    // Asynchronous reset in the middle of a frame
    $display("[TB] mid-frame reset");
    divVal = 0;
    divCnt = 0;
    startA = 1'b1;
    checkPixel(0, 0, 1);
    startA = 1'b0;
    for (int a = 1; a < 5; a++) checkPixel(a, (a == 4) ? 4 : 2, 1);
    checkPixel(5, 2, 0);
    resetN = 1'b0;
    #1;
    checkOutput("rst_rd_en", rdEnA, 0);
    checkOutput("rst_addr", rdAddrA, 0);
    checkOutput("rst_xy", {pixXA, pixYA}, 0);
    checkOutput("rst_markers", {lsA, fsA, feA}, 0);
    checkOutput("rst_busy", busyA, 0);
    repeat (2) applyStimulus();
    resetN = 1'b1;
    startA = 1'b1;
    checkPixel(0, 0, 1);
    startA = 1'b0;
    checkPixel(1, 2, 1);

    // No blanking, continuous: pixel on every tick across the frame wrap
    $display("[TB] no blanking");
    useB = 1'b1;
    startB = 1'b1;
    contB = 1'b1;
    checkPixel(0, 0, 1);
    startB = 1'b0;
    for (int a = 1; a < 8; a++) checkPixel(a, 2, 1);
    checkPixel(0, 2, 1);
    contB = 1'b0;
    for (int a = 1; a < 7; a++) checkPixel(a, 2, 1);
    checkOutput("b_busy_before_end", busyB, 1);
    checkPixel(7, 2, 0);
    checkOutput("b_busy_fall", busyB, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      if (rdEnB) cnt++;
    end
    checkOutput("b_idle_quiet", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_scan_gen.md
# pixel_scan_gen

Raster-scan pixel timing generator for the edge-detector pipeline, directly downstream of the programmable clock divider. It consumes the divider's `div_clk` output in the `origin_clk` domain and edge-detects it into a single-cycle pixel tick. From that tick it walks an IMG_W×IMG_H frame with horizontal and vertical blanking. It emits frame-buffer read strobes, addresses, coordinates and line/frame markers that the filter stages use.

## Interface
- IMG_W, 64: active pixels per line (≥2)
- IMG_H, 64: active lines per frame (≥2)
- HBLANK, 4: blank ticks after each line (0 allowed = no blanking)
- VBLANK, 8: blank ticks after each frame (0 allowed)
- ADDR_W, 12: read address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H
- origin_clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- div_clk  in  1  divider output, registered in origin_clk domain (no synchroniser)
- start  in  1  level; request scanning (sampled in IDLE)
- continuous  in  1  1 = repeat frames; 0 = stop after current frame
- rd_en  out  1  one-cycle read strobe per active pixel
- rd_addr  out  ADDR_W  y·IMG_W + x of pixel being read
- pix_x  out  $clog2(IMG_W)  current column
- pix_y  out  $clog2(IMG_H)  current row
- line_start  out  1  pulse with rd_en of x=0
- frame_start  out  1  pulse with rd_en of (0,0)
- frame_end  out  1  pulse with rd_en of (IMG_W-1, IMG_H-1)
- busy  out  1  high in any state except IDLE

## Operation
- Tick: `div_clk_d` register; tick = div_clk & ~div_clk_d (rising edge only). With divider value D, one tick every 2(D+1) cycles.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK. All transitions occur only on tick cycles.
- IDLE: on tick with start=1, go to ACTIVE and emit pixel (0,0) on that same tick. start=0 stays IDLE. start asserted between ticks is acted on only if still high at a tick.
- ACTIVE, each tick: emit current pixel (rd_en=1, addr/x/y), then advance x.
  - After x=IMG_W-1, go to HBLANK if HBLANK>0.
  - Else go to the next line directly.
  - After the last pixel of the frame, go to VBLANK, or to the frame-end decision if VBLANK=0.
- HBLANK: count HBLANK ticks (counter 0..HBLANK-1), then ACTIVE at x=0, y+1.
- VBLANK: count VBLANK ticks. Then:
  - continuous=1 → ACTIVE at (0,0), without re-checking start.
  - Else → IDLE.
- continuous is sampled only at the frame-end decision. Deasserting it mid-frame completes the frame.
- rd_addr is kept incrementally: +1 per pixel, 0 at frame wrap. No multiplier.
- x/y wrap: x IMG_W-1 → 0; y IMG_H-1 → 0.

## Timing
- Registered outputs. For tick in cycle T, rd_en, line_start, frame_start and frame_end are high in cycle T+1 only; rd_addr, pix_x and pix_y update in T+1 and hold until the next emitted pixel.
- Latency from div_clk rising (visible in cycle T) to rd_en is 1 cycle.
- Reset values:
  - FSM = IDLE.
  - div_clk_d=0, so div_clk high at reset release produces a tick.
  - rd_en, line_start, frame_start, frame_end, busy = 0.
  - rd_addr, pix_x, pix_y = 0.
- busy rises in T+1 of the starting tick. It falls in T+1 of the tick ending VBLANK (non-continuous).
- Async reset mid-frame: immediate return to reset values; no partial-frame completion.
- div_clk stuck (divider held in reset): no ticks, so state is frozen, outputs hold, and pulses stay low.

## Structure
- Shared package `edge_pkg`:
  - FSM state enum `scan_state_t`.
  - Default image dimensions, shared with downstream line buffers.
- Optional sub-module `rise_detect` (1-bit edge detector with async active-low reset). Reusable for other divided-clock consumers.
- Remainder in one module (~150–250 lines).

## Test plan
All scenarios use IMG_W=4, IMG_H=2, HBLANK=1, VBLANK=2 unless stated.
- Divider value 0, start=1, continuous=0 → ticks every 2 cycles.
  - rd_addr sequence 0,1,2,3,(1 blank),4,5,6,7, then 2 blank ticks.
  - busy falls after the 11th tick: 8 pixels + 1 HBLANK + 2 VBLANK.
- Markers → line_start with addr 0 and 4; frame_start only with addr 0; frame_end only with addr 7, each exactly 1 cycle wide.
- continuous=1 for 2 frames, then deasserted during frame 2 → addr 0 follows the last VBLANK tick of frame 1 with no gap; frame 2 completes; IDLE afterwards.
- HBLANK=0, VBLANK=0, continuous=1 → rd_en on every tick; addr 7 followed by 0 on the next tick.
- Async reset asserted at pixel addr 5 → all outputs 0 within the reset cycle. After release with start=1, the scan restarts at addr 0.
- Divider value 3 → rd_en spacing exactly 8 cycles. div_clk held low for 20 cycles → no rd_en and outputs unchanged.
